// File: rtl/ram_handshake_responder.sv
// ram_handshake_responder: 256-byte big-endian RAM answering the MOV/MOC
// handshake after LATENCY edges (legal range 1-15), holding MOC until MOV drops.
// Ports:
//   CLK      - clock; all state changes on the rising edge
//   CLR      - synchronous active-high reset (state, MOC, DataOut; not mem)
//   MOV      - request valid from the control unit
//   RW       - 1 read, 0 write (captured with MOV)
//   typeData - 00 byte, 01 halfword, 10/11 word
//   Address  - byte address; only [7:0] used, arithmetic wraps at 256
//   DataIn   - write data, right-justified for byte and halfword
//   DataOut  - registered read data, right-justified and zero-extended
//   MOC      - registered operation-complete flag
module ram_handshake_responder #(
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  typeData,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [7:0]  mem [0:255];

  state_t      state;
  state_t      state_nx;
  logic [3:0]  count;
  logic [3:0]  count_nx;
  logic        moc_nx;
  logic [31:0] dout_nx;

  logic [7:0]  cap_addr;
  logic        cap_rw;
  logic [1:0]  cap_type;
  logic [31:0] cap_data;

  logic        cap_en;
  logic        do_access;

  logic [7:0]  a0;
  logic [7:0]  a1;
  logic [7:0]  a2;
  logic [7:0]  a3;
  logic [31:0] rd_data;

  // Upper address bits are ignored by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Address[31:8];

  // Byte lanes of the captured address; 8-bit adds give the mod-256 wrap.
  assign a0 = cap_addr;
  assign a1 = cap_addr + 8'd1;
  assign a2 = cap_addr + 8'd2;
  assign a3 = cap_addr + 8'd3;

  always_comb begin
    rd_data = 32'd0;
    unique case (cap_type)
      2'b00:   rd_data = {24'd0, mem[a0]};
      2'b01:   rd_data = {16'd0, mem[a0], mem[a1]};
      default: rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    moc_nx    = MOC;
    dout_nx   = DataOut;
    cap_en    = 1'b0;
    do_access = 1'b0;
    unique case (state)
      IDLE: begin
        moc_nx = 1'b0;
        if (MOV) begin
          cap_en   = 1'b1;
          count_nx = CNT_LOAD;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (!MOV) begin
          // Abort: no access, no MOC, DataOut untouched.
          moc_nx   = 1'b0;
          state_nx = IDLE;
        end else if (count != 4'd0) begin
          count_nx = count - 4'd1;
        end else begin
          do_access = 1'b1;
          moc_nx    = 1'b1;
          state_nx  = ACK;
          if (cap_rw) begin
            dout_nx = rd_data;
          end
        end
      end
      ACK: begin
        moc_nx = 1'b1;
        if (!MOV) begin
          moc_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        moc_nx   = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state   <= IDLE;
      count   <= 4'd0;
      MOC     <= 1'b0;
      DataOut <= 32'd0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      MOC     <= moc_nx;
      DataOut <= dout_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR && cap_en) begin
      cap_addr <= Address[7:0];
      cap_rw   <= RW;
      cap_type <= typeData;
      cap_data <= DataIn;
    end
  end

  // Storage has no reset; CLR only cancels a pending write.
  always_ff @(posedge CLK) begin
    if (!CLR && do_access && !cap_rw) begin
      unique case (cap_type)
        2'b00: begin
          mem[a0] <= cap_data[7:0];
        end
        2'b01: begin
          mem[a0] <= cap_data[15:8];
          mem[a1] <= cap_data[7:0];
        end
        default: begin
          mem[a0] <= cap_data[31:24];
          mem[a1] <= cap_data[23:16];
          mem[a2] <= cap_data[15:8];
          mem[a3] <= cap_data[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_handshake_responder.sv
// tb_ram_handshake_responder: random and directed handshake traffic
// checked against a byte-array reference model of the RAM.
module tb_ram_handshake_responder;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        MOV;
  logic        RW;
  logic [1:0]  typeData;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ref_mem [256];
  logic [31:0] ref_dout;

  always #5 CLK = ~CLK;

  ram_handshake_responder #(.LATENCY(LAT)) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .MOV      (MOV),
    .RW       (RW),
    .typeData (typeData),
    .Address  (Address),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .MOC      (MOC)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] t);
    return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [7:0] a,
                                           input logic [1:0] t);
    logic [31:0] v = 0;
    for (int k = 0; k < nbytes(t); k++)
      v = (v << 8) | 32'(ref_mem[(int'(a) + k) % 256]);
    return v;
  endfunction

  task automatic ref_write(input logic [7:0] a, input logic [1:0] t,
                           input logic [31:0] d);
    int n = nbytes(t);
    for (int k = 0; k < n; k++)
      ref_mem[(int'(a) + k) % 256] = 8'(d >> (8 * (n - 1 - k)));
  endtask

  task automatic preload(input int a, input logic [7:0] v);
    ref_mem[a] = v;
    dut.mem[a] = v;
  endtask

  // Covers the touched bytes plus one on each side.
  task automatic check_near(input string tag, input logic [7:0] a);
    for (int k = -1; k < 5; k++) begin
      int idx = (int'(a) + k + 256) % 256;
      check(tag, 32'(dut.mem[idx]), 32'(ref_mem[idx]));
    end
  endtask

  task automatic do_op(input logic rw, input logic [1:0] t,
                       input logic [7:0] a, input logic [31:0] d,
                       input int hold, input string tag);
    int  lat = 0;
    bit  seen = 0;
    MOV      = 1'b1;
    RW       = rw;
    typeData = t;
    Address  = ($urandom() & 32'hFFFF_FF00) | 32'(a);
    DataIn   = d;
    tick;
    // Inputs after capture must not matter.
    RW       = ~rw;
    typeData = 2'($urandom());
    Address  = $urandom();
    DataIn   = $urandom();
    for (int i = 0; i < 40; i++) begin
      if (MOC) begin
        seen = 1;
        break;
      end
      tick;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    if (seen) begin
      if (rw) ref_dout = ref_read(a, t);
      else ref_write(a, t, d);
    end
    check({tag, "_dout"}, DataOut, ref_dout);
    check_near({tag, "_mem"}, a);
    for (int h = 0; h < hold; h++) begin
      tick;
      check({tag, "_hold_moc"}, 32'(MOC), 32'd1);
      check({tag, "_hold_dout"}, DataOut, ref_dout);
    end
    if (hold > 0) check_near({tag, "_hold_mem"}, a);
    MOV = 1'b0;
    tick;
    check({tag, "_moc_fall"}, 32'(MOC), 32'd0);
    check({tag, "_dout_keep"}, DataOut, ref_dout);
  endtask

  task automatic do_abort(input logic [7:0] a, input string tag);
    MOV      = 1'b1;
    RW       = 1'b0;
    typeData = 2'($urandom());
    Address  = 32'(a);
    DataIn   = $urandom();
    tick;
    MOV = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_moc"}, 32'(MOC), 32'd0);
      tick;
    end
    check({tag, "_dout"}, DataOut, ref_dout);
    check_near({tag, "_mem"}, a);
  endtask

  initial begin
    CLR      = 1'b1;
    MOV      = 1'b0;
    RW       = 1'b0;
    typeData = 2'd0;
    Address  = 32'd0;
    DataIn   = 32'd0;
    for (int i = 0; i < 256; i++) preload(i, 8'($urandom()));
    tick;
    tick;
    ref_dout = 32'd0;
    check("rst_moc", 32'(MOC), 32'd0);
    check("rst_dout", DataOut, 32'd0);
    CLR = 1'b0;
    tick;

    do_op(1'b0, 2'd2, 8'h04, 32'h1122_3344, 0, "w_word");
    do_op(1'b1, 2'd2, 8'h04, 32'h0, 0, "r_word");
    check("r_word_val", DataOut, 32'h1122_3344);
    do_op(1'b1, 2'd0, 8'h05, 32'h0, 0, "r_byte");
    check("r_byte_val", DataOut, 32'h0000_0022);
    do_op(1'b1, 2'd1, 8'h06, 32'h0, 0, "r_half");
    check("r_half_val", DataOut, 32'h0000_3344);
    do_op(1'b0, 2'd0, 8'h04, 32'hAABB_CCDD, 0, "w_byte");
    check("w_byte_m4", 32'(dut.mem[4]), 32'hDD);
    check("w_byte_m5", 32'(dut.mem[5]), 32'h22);

    preload(8'hFE, 8'h01);
    preload(8'hFF, 8'h02);
    preload(8'h00, 8'h03);
    preload(8'h01, 8'h04);
    do_op(1'b1, 2'd2, 8'hFE, 32'h0, 0, "r_wrap");
    check("r_wrap_val", DataOut, 32'h0102_0304);
    do_op(1'b0, 2'd1, 8'hFF, 32'h0000_BEEF, 0, "w_wrap");
    check("w_wrap_ff", 32'(dut.mem[255]), 32'hBE);
    check("w_wrap_00", 32'(dut.mem[0]), 32'hEF);
    do_op(1'b1, 2'd3, 8'hFE, 32'h0, 0, "r_t3");

    do_op(1'b1, 2'd2, 8'h20, 32'h0, 5, "hold_r");
    do_op(1'b0, 2'd2, 8'h24, $urandom(), 5, "hold_w");
    do_op(1'b1, 2'd2, 8'h24, 32'h0, 0, "hold_rb");

    preload(8'h10, 8'h5A);
    do_abort(8'h10, "abort");
    check("abort_m10", 32'(dut.mem[16]), 32'h5A);

    MOV      = 1'b1;
    RW       = 1'b0;
    typeData = 2'd2;
    Address  = 32'h40;
    DataIn   = 32'hDEAD_BEEF;
    tick;
    CLR = 1'b1;
    tick;
    ref_dout = 32'd0;
    check("clr_moc", 32'(MOC), 32'd0);
    check("clr_dout", DataOut, 32'd0);
    CLR = 1'b0;
    MOV = 1'b0;
    tick;
    check_near("clr_mem", 8'h40);
    do_op(1'b1, 2'd2, 8'h40, 32'h0, 0, "clr_rd");
    do_op(1'b0, 2'd2, 8'h40, 32'hCAFE_F00D, 0, "clr_wr");
    do_op(1'b1, 2'd2, 8'h40, 32'h0, 0, "clr_rd2");
    check("clr_rd2_val", DataOut, 32'hCAFE_F00D);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] a = 8'($urandom());
      if ($urandom_range(7) == 0) begin
        do_abort(a, "rnd_abort");
      end else begin
        do_op(1'($urandom()), 2'($urandom()), a, $urandom(),
              int'($urandom_range(3)), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
